// File: rtl/g76_video_pkg.sv
// Shared constants for the video write path: register map, CONTROL bits,
// sequencer states and coordinate widths.
package g76_video_pkg;

  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int D_W = 8;

  localparam logic [3:0] REG_X_LOW          = 4'd0;
  localparam logic [3:0] REG_X_HIGH         = 4'd1;
  localparam logic [3:0] REG_Y              = 4'd2;
  localparam logic [3:0] REG_DATA           = 4'd3;
  localparam logic [3:0] REG_BOX_X_START_LO = 4'd4;
  localparam logic [3:0] REG_BOX_X_START_HI = 4'd5;
  localparam logic [3:0] REG_BOX_X_STOP_LO  = 4'd6;
  localparam logic [3:0] REG_BOX_X_STOP_HI  = 4'd7;
  localparam logic [3:0] REG_BOX_Y_START    = 4'd8;
  localparam logic [3:0] REG_BOX_Y_STOP     = 4'd9;
  localparam logic [3:0] REG_CONTROL        = 4'd10;
  localparam logic [3:0] REG_FILL_COLOR     = 4'd11;

  localparam int CTRL_AUTO_ADVANCE   = 0;
  localparam int CTRL_FILL_START     = 1;
  localparam int CTRL_CLEAR_OVERFLOW = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PIXEL = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

endpackage

// File: rtl/box_cursor_step.sv
// Raster step inside a box: X runs start..stop, then wraps and Y advances.
// The >= compares collapse a degenerate (stop < start) axis to its start value.
module box_cursor_step #(
  parameter int X_WIDTH = 9,
  parameter int Y_WIDTH = 8
) (
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  input  logic [X_WIDTH-1:0] xStart,
  input  logic [X_WIDTH-1:0] xStop,
  input  logic [Y_WIDTH-1:0] yStart,
  input  logic [Y_WIDTH-1:0] yStop,
  output logic [X_WIDTH-1:0] nextX,
  output logic [Y_WIDTH-1:0] nextY
);

  // next raster position
  always_comb begin
    nextX = x;
    nextY = y;
    if (x >= xStop) begin
      nextX = xStart;
      if (y >= yStop) begin
        nextY = yStart;
      end else begin
        nextY = y + Y_WIDTH'(1);
      end
    end else begin
      nextX = x + X_WIDTH'(1);
      nextY = y;
    end
  end

endmodule

// File: rtl/autobox_write_sequencer.sv
// Turns MCU register writes into memory write handshakes: cursor/box
// auto-advance, a one-deep pending pixel and a hardware rectangle fill.
import g76_video_pkg::*;

module autobox_write_sequencer #(
  parameter int X_WIDTH    = X_W,
  parameter int Y_WIDTH    = Y_W,
  parameter int DATA_WIDTH = D_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  regWrite,
  input  logic [3:0]            regSelect,
  input  logic [7:0]            regData,
  output logic [X_WIDTH-1:0]    memoryXCoord,
  output logic [Y_WIDTH-1:0]    memoryYCoord,
  output logic [DATA_WIDTH-1:0] memoryWriteData,
  output logic                  memoryWriteRequest,
  input  logic                  memoryWriteComplete,
  output logic                  busy,
  output logic                  overflow
);

  logic [X_WIDTH-1:0]    cursorX, boxXStart, boxXStop, fX, pendX, curNextX, fillNextX;
  logic [Y_WIDTH-1:0]    cursorY, boxYStart, boxYStop, fY, pendY, curNextY, fillNextY;
  logic [DATA_WIDTH-1:0] fillColor, pendData;
  logic                  autoAdvance, fillGo, fillCont, pendValid;
  logic [1:0]            state;
  logic dataPush, ctrlWrite, pendTake, pushAccept, fillStartReq, fillAccept, fillLaunch;

  box_cursor_step #(.X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH)) cursorStep (
    .x(cursorX), .y(cursorY), .xStart(boxXStart), .xStop(boxXStop),
    .yStart(boxYStart), .yStop(boxYStop), .nextX(curNextX), .nextY(curNextY)
  );

  box_cursor_step #(.X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH)) fillStep (
    .x(fX), .y(fY), .xStart(boxXStart), .xStop(boxXStop),
    .yStart(boxYStart), .yStop(boxYStop), .nextX(fillNextX), .nextY(fillNextY)
  );

  // strobe decode; a push is accepted if the pending slot is free or being drained this cycle
  always_comb begin
    dataPush     = regWrite && (regSelect == REG_DATA);
    ctrlWrite    = regWrite && (regSelect == REG_CONTROL);
    pendTake     = (state == ST_IDLE) && pendValid;
    pushAccept   = dataPush && (!pendValid || pendTake);
    fillStartReq = ctrlWrite && regData[CTRL_FILL_START];
    fillAccept   = fillStartReq && (state == ST_IDLE) && !pendValid && !fillGo;
    fillLaunch   = (state == ST_IDLE) && !pendValid && fillGo;
  end

  assign busy = (state != ST_IDLE) || pendValid;

  // register file and cursor
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cursorX <= '0; cursorY <= '0; boxXStart <= '0; boxXStop <= '0;
      boxYStart <= '0; boxYStop <= '0; autoAdvance <= 1'b0; fillColor <= '0;
    end else if (regWrite) begin
      case (regSelect)
        REG_X_LOW:          cursorX[7:0] <= regData;
        REG_X_HIGH:         cursorX[X_WIDTH-1] <= regData[0];
        REG_Y:              cursorY <= regData;
        REG_DATA: begin
          if (pushAccept && autoAdvance) begin
            cursorX <= curNextX;
            cursorY <= curNextY;
          end
        end
        REG_BOX_X_START_LO: boxXStart[7:0] <= regData;
        REG_BOX_X_START_HI: boxXStart[X_WIDTH-1] <= regData[0];
        REG_BOX_X_STOP_LO:  boxXStop[7:0] <= regData;
        REG_BOX_X_STOP_HI:  boxXStop[X_WIDTH-1] <= regData[0];
        REG_BOX_Y_START:    boxYStart <= regData;
        REG_BOX_Y_STOP:     boxYStop <= regData;
        REG_CONTROL:        autoAdvance <= regData[CTRL_AUTO_ADVANCE];
        REG_FILL_COLOR:     fillColor <= regData;
        default:            ;
      endcase
    end
  end

  // pending pixel slot, fill-start latch and sticky overflow
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pendValid <= 1'b0; pendX <= '0; pendY <= '0; pendData <= '0;
      fillGo <= 1'b0; overflow <= 1'b0;
    end else begin
      if (pushAccept) begin
        pendValid <= 1'b1;
        pendX     <= cursorX;
        pendY     <= cursorY;
        pendData  <= regData;
      end else if (pendTake) begin
        pendValid <= 1'b0;
      end
      if (fillAccept) begin
        fillGo <= 1'b1;
      end else if (fillLaunch) begin
        fillGo <= 1'b0;
      end
      if ((dataPush && !pushAccept) || (fillStartReq && !fillAccept)) begin
        overflow <= 1'b1;
      end else if (ctrlWrite && regData[CTRL_CLEAR_OVERFLOW]) begin
        overflow <= 1'b0;
      end
    end
  end

  // write handshake sequencer; GAP forces one request-low cycle between writes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE; fX <= '0; fY <= '0; fillCont <= 1'b0;
      memoryXCoord <= '0; memoryYCoord <= '0; memoryWriteData <= '0;
      memoryWriteRequest <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pendTake) begin
            memoryXCoord       <= pendX;
            memoryYCoord       <= pendY;
            memoryWriteData    <= pendData;
            memoryWriteRequest <= 1'b1;
            state              <= ST_PIXEL;
          end else if (fillLaunch) begin
            fX                 <= boxXStart;
            fY                 <= boxYStart;
            memoryXCoord       <= boxXStart;
            memoryYCoord       <= boxYStart;
            memoryWriteData    <= fillColor;
            memoryWriteRequest <= 1'b1;
            state              <= ST_FILL;
          end
        end
        ST_PIXEL: begin
          if (memoryWriteComplete) begin
            memoryWriteRequest <= 1'b0;
            state              <= ST_GAP;
          end
        end
        ST_FILL: begin
          if (memoryWriteComplete) begin
            memoryWriteRequest <= 1'b0;
            state              <= ST_GAP;
            if ((fX >= boxXStop) && (fY >= boxYStop)) begin
              fillCont <= 1'b0;
            end else begin
              fX           <= fillNextX;
              fY           <= fillNextY;
              memoryXCoord <= fillNextX;
              memoryYCoord <= fillNextY;
              fillCont     <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (fillCont) begin
            memoryWriteRequest <= 1'b1;
            fillCont           <= 1'b0;
            state              <= ST_FILL;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          memoryWriteRequest <= 1'b0;
          state              <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_autobox_write_sequencer.sv
// Scoreboard bench: expected writes are queued as registers are written and
// checked when the DUT raises its write request.
module tb_autobox_write_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       regWrite;
  logic [3:0] regSelect;
  logic [7:0] regData;
  logic [8:0] memoryXCoord;
  logic [7:0] memoryYCoord;
  logic [7:0] memoryWriteData;
  logic       memoryWriteRequest;
  logic       memoryWriteComplete;
  logic       busy;
  logic       overflow;

  int total = 0;
  int bad = 0;
  logic [24:0] expQ[$];

  autobox_write_sequencer dut (
    .clock(clock), .reset(reset), .regWrite(regWrite), .regSelect(regSelect),
    .regData(regData), .memoryXCoord(memoryXCoord), .memoryYCoord(memoryYCoord),
    .memoryWriteData(memoryWriteData), .memoryWriteRequest(memoryWriteRequest),
    .memoryWriteComplete(memoryWriteComplete), .busy(busy), .overflow(overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic regWr(input logic [3:0] sel, input logic [7:0] d);
    @(negedge clock);
    regWrite = 1'b1; regSelect = sel; regData = d;
    @(negedge clock);
    regWrite = 1'b0;
  endtask

  task automatic serviceWrite(input int lat);
    int waitCnt;
    logic [24:0] got;
    logic [24:0] exp;
    waitCnt = 0;
    while (memoryWriteRequest !== 1'b1 && waitCnt < 100) begin
      @(negedge clock);
      waitCnt++;
    end
    total++;
    if (memoryWriteRequest !== 1'b1) begin
      $display("FAIL req_timeout got=%b exp=1", memoryWriteRequest);
      bad++;
      return;
    end
    total++;
    if (expQ.size() == 0) begin
      $display("FAIL unexpected_write got=(%0d,%0d,%h) exp=none", memoryXCoord, memoryYCoord, memoryWriteData);
      bad++;
      exp = 25'h0;
    end else begin
      exp = expQ.pop_front();
      got = {memoryXCoord, memoryYCoord, memoryWriteData};
      if (got !== exp) begin
        $display("FAIL write_value got=(%0d,%0d,%h) exp=(%0d,%0d,%h)", got[24:16], got[15:8], got[7:0], exp[24:16], exp[15:8], exp[7:0]);
        bad++;
      end
    end
    repeat (lat) @(negedge clock);
    total++;
    got = {memoryXCoord, memoryYCoord, memoryWriteData};
    if (memoryWriteRequest !== 1'b1 || got !== exp) begin
      $display("FAIL write_hold got=%b/%h exp=1/%h", memoryWriteRequest, got, exp);
      bad++;
    end
    memoryWriteComplete = 1'b1;
    @(negedge clock);
    memoryWriteComplete = 1'b0;
    total++;
    if (memoryWriteRequest !== 1'b0) begin
      $display("FAIL gap_low got=%b exp=0", memoryWriteRequest);
      bad++;
    end
  endtask

  task automatic test_reset();
    int waitCnt;
    reset = 1'b1; regWrite = 1'b0; regSelect = 4'd0; regData = 8'd0;
    memoryWriteComplete = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++;
    if ({memoryXCoord, memoryYCoord, memoryWriteData, memoryWriteRequest, busy, overflow} !== 28'h0) begin
      $display("FAIL reset_state got=%h exp=0", {memoryXCoord, memoryYCoord, memoryWriteData, memoryWriteRequest, busy, overflow});
      bad++;
    end
    regWr(4'd0, 8'd1); regWr(4'd2, 8'd1); regWr(4'd3, 8'd9);
    waitCnt = 0;
    while (memoryWriteRequest !== 1'b1 && waitCnt < 20) begin
      @(negedge clock);
      waitCnt++;
    end
    total++;
    if (memoryWriteRequest !== 1'b1) begin
      $display("FAIL pre_reset_req got=%b exp=1", memoryWriteRequest);
      bad++;
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({memoryXCoord, memoryYCoord, memoryWriteData, memoryWriteRequest, busy} !== 27'h0) begin
      $display("FAIL reset_mid_req got=%h exp=0", {memoryXCoord, memoryYCoord, memoryWriteData, memoryWriteRequest, busy});
      bad++;
    end
    @(negedge clock);
    reset = 1'b0;
    regWr(4'd0, 8'd4); regWr(4'd2, 8'd4);
    expQ.push_back({9'd4, 8'd4, 8'd5});
    regWr(4'd3, 8'd5);
    serviceWrite(1);
  endtask

  task automatic test_no_advance();
    regWr(4'd10, 8'd0);
    regWr(4'd0, 8'h05); regWr(4'd1, 8'h01); regWr(4'd2, 8'd2);
    expQ.push_back({9'd261, 8'd2, 8'd3});
    regWr(4'd3, 8'd3);
    total++;
    if (memoryWriteRequest !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL latency_n1 got=req%b/busy%b exp=req0/busy1", memoryWriteRequest, busy);
      bad++;
    end
    @(negedge clock);
    total++;
    if (memoryWriteRequest !== 1'b1) begin
      $display("FAIL latency_n2 got=%b exp=1", memoryWriteRequest);
      bad++;
    end
    serviceWrite(3);
    @(negedge clock);
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL idle_busy got=%b exp=0", busy);
      bad++;
    end
    expQ.push_back({9'd261, 8'd2, 8'd4});
    regWr(4'd3, 8'd4);
    serviceWrite(0);
  endtask

  task automatic test_auto_advance();
    regWr(4'd4, 8'd10); regWr(4'd5, 8'd0); regWr(4'd6, 8'd12); regWr(4'd7, 8'd0);
    regWr(4'd8, 8'd5); regWr(4'd9, 8'd6); regWr(4'd10, 8'd1);
    regWr(4'd0, 8'd12); regWr(4'd1, 8'd0); regWr(4'd2, 8'd6);
    expQ.push_back({9'd12, 8'd6, 8'h11});
    regWr(4'd3, 8'h11);
    expQ.push_back({9'd10, 8'd5, 8'h22});
    regWr(4'd3, 8'h22);
    serviceWrite(1);
    serviceWrite(2);
    total++;
    if (overflow !== 1'b0) begin
      $display("FAIL adv_no_overflow got=%b exp=0", overflow);
      bad++;
    end
  endtask

  task automatic test_fill_and_overflow();
    regWr(4'd4, 8'd0); regWr(4'd5, 8'd0); regWr(4'd6, 8'd2); regWr(4'd7, 8'd0);
    regWr(4'd8, 8'd0); regWr(4'd9, 8'd1); regWr(4'd11, 8'hAA);
    regWr(4'd0, 8'd7); regWr(4'd1, 8'd0); regWr(4'd2, 8'd9);
    for (int yy = 0; yy < 2; yy++) begin
      for (int xx = 0; xx < 3; xx++) begin
        expQ.push_back({9'(xx), 8'(yy), 8'hAA});
      end
    end
    regWr(4'd10, 8'h02);
    expQ.push_back({9'd7, 8'd9, 8'h33});
    regWr(4'd3, 8'h33);
    regWr(4'd3, 8'h44);
    total++;
    if (overflow !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL drop_overflow got=ovf%b/busy%b exp=ovf1/busy1", overflow, busy);
      bad++;
    end
    for (int i = 0; i < 7; i++) serviceWrite(i % 3);
    repeat (3) @(negedge clock);
    total++;
    if (busy !== 1'b0 || memoryWriteRequest !== 1'b0 || expQ.size() != 0) begin
      $display("FAIL fill_done got=busy%b/req%b/left%0d exp=0/0/0", busy, memoryWriteRequest, expQ.size());
      bad++;
    end
    regWr(4'd10, 8'h04);
    total++;
    if (overflow !== 1'b0) begin
      $display("FAIL overflow_clear got=%b exp=0", overflow);
      bad++;
    end
  endtask

  task automatic test_degenerate_fill();
    int extra;
    regWr(4'd4, 8'd5); regWr(4'd6, 8'd3); regWr(4'd8, 8'd7); regWr(4'd9, 8'd7);
    regWr(4'd11, 8'h5C);
    expQ.push_back({9'd5, 8'd7, 8'h5C});
    regWr(4'd10, 8'h02);
    serviceWrite(1);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (memoryWriteRequest === 1'b1) extra++;
    end
    total++;
    if (extra != 0 || busy !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL degenerate_single got=extra%0d/busy%b/ovf%b exp=0/0/0", extra, busy, overflow);
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_no_advance();
    test_auto_advance();
    test_fill_and_overflow();
    test_degenerate_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
